cpu_sequencer: RTL and testbench

- Next-generation M6502 control unit: owns the one-hot timing register, the opcode latch and the operand latch, and drives the per-cycle datapath strobes itself.
- Adds zero-page load/store, absolute JMP with a latched low byte, a ready stall, and illegal-opcode handling. None of these exist in the current pure-combinational decode.
- Sits between the memory data bus and the register/PC datapath.

---
 rtl/cpu_sequencer_if.sv | 34 +++
 rtl/cpu_sequencer.sv | 104 ++++++++++
 tb/tb_cpu_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Bus between the M6502 control unit (master) and the memory/register datapath (slave).
// Carries the fetched byte and ready stall in, plus the timing state and per-cycle strobes out.
interface cpu_sequencer_if #(
  parameter int TIMING_W = 8
);
  logic [7:0]          data_in;
  logic                ready;
  logic [7:0]          opcode;
  logic [TIMING_W-1:0] timing;
  logic                sync;
  logic                pc_inc;
  logic                pc_load;
  logic [7:0]          operand_lo;
  logic                addr_sel;
  logic                write_en;
  logic [1:0]          store_sel;
  logic                ra_load;
  logic                rx_load;
  logic                ry_load;
  logic                illegal;
  logic                halted;

  modport master (
    input  data_in, ready,
    output opcode, timing, sync, pc_inc, pc_load, operand_lo, addr_sel,
           write_en, store_sel, ra_load, rx_load, ry_load, illegal, halted
  );

  modport slave (
    output data_in, ready,
    input  opcode, timing, sync, pc_inc, pc_load, operand_lo, addr_sel,
           write_en, store_sel, ra_load, rx_load, ry_load, illegal, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// M6502 control unit: one-hot timing, opcode/operand latches, combinational strobes; 2-3 cycles/instr.
// Backpressure: ready=0 freezes all state and zeroes every strobe for that cycle.
module cpu_sequencer #(
  parameter int         TIMING_W        = 8,
  parameter bit         HALT_ON_ILLEGAL = 1'b0,
  parameter logic [7:0] RESET_OPCODE    = 8'hEA
) (
  input logic             clock,
  input logic             reset,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    OP_NOP, OP_LDI, OP_LDZ, OP_STZ, OP_JMP, OP_ILL
  } op_class_t;

  localparam logic [TIMING_W-1:0] T0_V = TIMING_W'(1);
  localparam logic [TIMING_W-1:0] T1_V = TIMING_W'(2);

  logic [TIMING_W-1:0] timing_q;
  logic [7:0]          opcode_q;
  logic [7:0]          operand_q;
  logic                halted_q;

  op_class_t op_class;
  logic [1:0] op_reg;
  logic t0, t1, t2, top;
  logic three_cycle, end_now, runaway, gate, load_r;

  always_comb begin
    op_class = OP_ILL;
    op_reg   = 2'd0;
    case (opcode_q)
      8'hEA: op_class = OP_NOP;
      8'hA9: begin op_class = OP_LDI; op_reg = 2'd0; end
      8'hA2: begin op_class = OP_LDI; op_reg = 2'd1; end
      8'hA0: begin op_class = OP_LDI; op_reg = 2'd2; end
      8'hA5: begin op_class = OP_LDZ; op_reg = 2'd0; end
      8'hA6: begin op_class = OP_LDZ; op_reg = 2'd1; end
      8'hA4: begin op_class = OP_LDZ; op_reg = 2'd2; end
      8'h85: begin op_class = OP_STZ; op_reg = 2'd0; end
      8'h86: begin op_class = OP_STZ; op_reg = 2'd1; end
      8'h84: begin op_class = OP_STZ; op_reg = 2'd2; end
      8'h4C: op_class = OP_JMP;
      default: ;
    endcase
  end

  assign t0  = timing_q[0];
  assign t1  = timing_q[1];
  assign t2  = timing_q[2];
  assign top = timing_q[TIMING_W-1];

  assign three_cycle = (op_class == OP_LDZ) || (op_class == OP_STZ) || (op_class == OP_JMP);
  assign end_now = (t1 && ((op_class == OP_NOP) || (op_class == OP_LDI) ||
                           ((op_class == OP_ILL) && !HALT_ON_ILLEGAL))) ||
                   (t2 && three_cycle);
  // A timing bit past any legal end recovers to T0 and flags it.
  assign runaway = top && !end_now;
  assign gate    = bus.ready && !halted_q && !reset;
  assign load_r  = (t1 && (op_class == OP_LDI)) || (t2 && (op_class == OP_LDZ));

  always_comb begin
    bus.pc_inc    = gate && (t0 || (t1 && ((op_class == OP_LDI) || three_cycle)));
    bus.pc_load   = gate && t2 && (op_class == OP_JMP);
    bus.write_en  = gate && t2 && (op_class == OP_STZ);
    bus.ra_load   = gate && load_r && (op_reg == 2'd0);
    bus.rx_load   = gate && load_r && (op_reg == 2'd1);
    bus.ry_load   = gate && load_r && (op_reg == 2'd2);
    bus.illegal   = gate && ((t1 && (op_class == OP_ILL)) || runaway);
    bus.addr_sel  = t2 && ((op_class == OP_LDZ) || (op_class == OP_STZ));
    bus.store_sel = (t2 && (op_class == OP_STZ)) ? op_reg : 2'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timing_q  <= T0_V;
      opcode_q  <= RESET_OPCODE;
      operand_q <= 8'h00;
      halted_q  <= 1'b0;
    end else if (bus.ready && !halted_q) begin
      if (t0) begin
        opcode_q <= bus.data_in;
        timing_q <= T1_V;
      end else if (end_now || runaway) begin
        timing_q <= T0_V;
      end else if (t1 && (op_class == OP_ILL) && HALT_ON_ILLEGAL) begin
        halted_q <= 1'b1;
      end else begin
        timing_q <= timing_q << 1;
      end
      if (t1 && three_cycle) begin
        operand_q <= bus.data_in;
      end
    end
  end

  assign bus.timing     = timing_q;
  assign bus.opcode     = opcode_q;
  assign bus.operand_lo = operand_q;
  assign bus.halted     = halted_q;
  assign bus.sync       = timing_q[0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench: two sequencers (continue / halt on illegal) share one byte stream, checked against an instruction-level model.
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  bit model_ok = 1'b0;

  always #5 clock = ~clock;

  cpu_sequencer_if #(.TIMING_W(8)) b0 ();
  cpu_sequencer_if #(.TIMING_W(8)) b1 ();

  assign b0.data_in = data_in;
  assign b0.ready   = ready;
  assign b1.data_in = data_in;
  assign b1.ready   = ready;

  cpu_sequencer #(.TIMING_W(8), .HALT_ON_ILLEGAL(1'b0), .RESET_OPCODE(8'hEA)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.master)
  );
  cpu_sequencer #(.TIMING_W(8), .HALT_ON_ILLEGAL(1'b1), .RESET_OPCODE(8'hEA)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.master)
  );

  typedef struct packed {
    logic       sync;
    logic       pc_inc;
    logic       pc_load;
    logic       addr_sel;
    logic       write_en;
    logic [1:0] store_sel;
    logic       ra;
    logic       rx;
    logic       ry;
    logic       illegal;
    logic       halted;
    logic [7:0] opcode;
    logic [7:0] operand_lo;
    logic [7:0] timing;
  } obs_t;

  obs_t act [2];
  assign act[0] = {b0.sync, b0.pc_inc, b0.pc_load, b0.addr_sel, b0.write_en, b0.store_sel,
                   b0.ra_load, b0.rx_load, b0.ry_load, b0.illegal, b0.halted,
                   b0.opcode, b0.operand_lo, b0.timing};
  assign act[1] = {b1.sync, b1.pc_inc, b1.pc_load, b1.addr_sel, b1.write_en, b1.store_sel,
                   b1.ra_load, b1.rx_load, b1.ry_load, b1.illegal, b1.halted,
                   b1.opcode, b1.operand_lo, b1.timing};

  // Instruction-level model: cycle index within the instruction, not a timing vector.
  int         m_phase [2];
  logic [7:0] m_op    [2];
  logic [7:0] m_opl   [2];
  bit         m_halt  [2];

  logic [7:0] legal [11] = '{8'hEA, 8'hA9, 8'hA2, 8'hA0, 8'hA5, 8'hA6,
                             8'hA4, 8'h85, 8'h86, 8'h84, 8'h4C};

  // kind: 0 NOP, 1 load immediate, 2 load zp, 3 store zp, 4 JMP, 5 unknown
  function automatic void decode(input logic [7:0] op, output int kind, output logic [1:0] rg);
    kind = 5;
    rg   = 2'd0;
    case (op)
      8'hEA: kind = 0;
      8'hA9: begin kind = 1; rg = 2'd0; end
      8'hA2: begin kind = 1; rg = 2'd1; end
      8'hA0: begin kind = 1; rg = 2'd2; end
      8'hA5: begin kind = 2; rg = 2'd0; end
      8'hA6: begin kind = 2; rg = 2'd1; end
      8'hA4: begin kind = 2; rg = 2'd2; end
      8'h85: begin kind = 3; rg = 2'd0; end
      8'h86: begin kind = 3; rg = 2'd1; end
      8'h84: begin kind = 3; rg = 2'd2; end
      8'h4C: kind = 4;
      default: ;
    endcase
  endfunction

  function automatic obs_t expect_out(input int i);
    obs_t       e;
    int         kind;
    logic [1:0] rg;
    bit         en;
    bit         ld;
    decode(m_op[i], kind, rg);
    e            = '0;
    e.timing     = 8'(1 << m_phase[i]);
    e.sync       = (m_phase[i] == 0);
    e.opcode     = m_op[i];
    e.operand_lo = m_opl[i];
    e.halted     = m_halt[i];
    en = ready && !m_halt[i] && !reset;
    ld = 1'b0;
    if (m_phase[i] == 0) begin
      e.pc_inc = en;
    end else if (m_phase[i] == 1) begin
      e.pc_inc  = en && (kind >= 1) && (kind <= 4);
      e.illegal = en && (kind == 5);
      ld        = en && (kind == 1);
    end else begin
      e.addr_sel = (kind == 2) || (kind == 3);
      if (kind == 3) begin
        e.store_sel = rg;
        e.write_en  = en;
      end
      e.pc_load = en && (kind == 4);
      ld        = en && (kind == 2);
    end
    e.ra = ld && (rg == 2'd0);
    e.rx = ld && (rg == 2'd1);
    e.ry = ld && (rg == 2'd2);
    return e;
  endfunction

  task automatic model_step();
    int         kind;
    logic [1:0] rg;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0;
        m_op[i]    = 8'hEA;
        m_opl[i]   = 8'h00;
        m_halt[i]  = 1'b0;
      end else if (ready && !m_halt[i]) begin
        decode(m_op[i], kind, rg);
        if (m_phase[i] == 0) begin
          m_op[i]    = data_in;
          m_phase[i] = 1;
        end else if (m_phase[i] == 1) begin
          if (kind >= 2 && kind <= 4) begin
            m_opl[i]   = data_in;
            m_phase[i] = 2;
          end else if (kind == 5 && i == 1) begin
            m_halt[i] = 1'b1;
          end else begin
            m_phase[i] = 0;
          end
        end else begin
          m_phase[i] = 0;
        end
      end
    end
    model_ok = 1'b1;
  endtask

  task automatic compare_all();
    obs_t e;
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        e = expect_out(i);
        n_vec++;
        if (act[i] !== e) begin
          n_err++;
          $display("FAIL cycle dut%0d t=%0t: got %h want %h", i, $time, act[i], e);
        end
      end
    end
  endtask

  task automatic pin(input string nm, input logic [15:0] a, input logic [15:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, x);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic drive(input logic [7:0] d, input logic r, input logic rs);
    data_in = d;
    ready   = r;
    reset   = rs;
    #3;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  initial begin
    logic [7:0] st_ops [3];
    logic [7:0] d;
    st_ops = '{8'h85, 8'h86, 8'h84};
    #1;
    drive(8'h00, 1'b1, 1'b1); tick();

    drive(8'h00, 1'b1, 1'b1);
    pin("reset_timing", 16'(b0.timing), 16'h0001);
    pin("reset_opcode", 16'(b0.opcode), 16'h00EA);
    pin("reset_pc_inc", 16'(b0.pc_inc), 16'h0000);
    tick();

    drive(8'hA9, 1'b1, 1'b0);
    pin("lda_t0_sync", 16'(b0.sync), 16'h0001);
    pin("lda_t0_pcinc", 16'(b0.pc_inc), 16'h0001);
    tick();
    drive(8'h42, 1'b1, 1'b0);
    pin("lda_t1_raload", 16'(b0.ra_load), 16'h0001);
    pin("lda_t1_pcinc", 16'(b0.pc_inc), 16'h0001);
    tick();
    drive(8'hEA, 1'b1, 1'b0);
    pin("lda_end_timing", 16'(b0.timing), 16'h0001);
    pin("lda_opcode", 16'(b0.opcode), 16'h00A9);
    tick();
    drive(8'h00, 1'b1, 1'b0); tick();

    for (int k = 0; k < 3; k++) begin
      drive(st_ops[k], 1'b1, 1'b0); tick();
      drive(8'h10, 1'b1, 1'b0); tick();
      drive(8'h00, 1'b1, 1'b0);
      pin("st_t2_addrsel", 16'(b0.addr_sel), 16'h0001);
      pin("st_t2_write", 16'(b0.write_en), 16'h0001);
      pin("st_t2_storesel", 16'(b0.store_sel), 16'(k));
      pin("st_t2_operand", 16'(b0.operand_lo), 16'h0010);
      tick();
    end

    drive(8'h4C, 1'b1, 1'b0); tick();
    drive(8'h34, 1'b1, 1'b0); tick();
    drive(8'h12, 1'b1, 1'b0);
    pin("jmp_t2_pcload", 16'(b0.pc_load), 16'h0001);
    pin("jmp_t2_pcinc", 16'(b0.pc_inc), 16'h0000);
    pin("jmp_t2_operand", 16'(b0.operand_lo), 16'h0034);
    tick();
    drive(8'hEA, 1'b1, 1'b0);
    pin("jmp_next_sync", 16'(b0.sync), 16'h0001);
    tick();
    drive(8'h00, 1'b1, 1'b0); tick();

    drive(8'hA6, 1'b1, 1'b0); tick();
    drive(8'h20, 1'b1, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(8'h55, 1'b0, 1'b0);
      pin("stall_timing", 16'(b0.timing), 16'h0004);
      pin("stall_rxload", 16'(b0.rx_load), 16'h0000);
      tick();
    end
    drive(8'h55, 1'b1, 1'b0);
    pin("unstall_rxload", 16'(b0.rx_load), 16'h0001);
    tick();
    drive(8'hEA, 1'b1, 1'b0);
    pin("unstall_t0", 16'(b0.timing), 16'h0001);
    tick();
    drive(8'h00, 1'b1, 1'b0); tick();

    drive(8'h02, 1'b1, 1'b0); tick();
    drive(8'h77, 1'b1, 1'b0);
    pin("ill_pulse_nohalt", 16'(b0.illegal), 16'h0001);
    pin("ill_pulse_halt", 16'(b1.illegal), 16'h0001);
    tick();
    drive(8'hEA, 1'b1, 1'b0);
    pin("ill_back_t0", 16'(b0.timing), 16'h0001);
    pin("ill_halted", 16'(b1.halted), 16'h0001);
    pin("ill_halt_t1", 16'(b1.timing), 16'h0002);
    pin("ill_halt_quiet", 16'(b1.illegal | b1.pc_inc), 16'h0000);
    tick();
    drive(8'h00, 1'b1, 1'b0); tick();
    drive(8'h00, 1'b1, 1'b1); tick();
    drive(8'hA9, 1'b1, 1'b0);
    pin("halt_reset_timing", 16'(b1.timing), 16'h0001);
    pin("halt_reset_opcode", 16'(b1.opcode), 16'h00EA);
    pin("halt_reset_halted", 16'(b1.halted), 16'h0000);
    tick();
    drive(8'h01, 1'b1, 1'b0); tick();

    drive(8'h85, 1'b1, 1'b0); tick();
    drive(8'h10, 1'b1, 1'b0); tick();
    drive(8'h00, 1'b1, 1'b1);
    pin("rst_t2_write", 16'(b0.write_en), 16'h0000);
    tick();
    drive(8'hEA, 1'b1, 1'b0);
    pin("rst_t2_timing", 16'(b0.timing), 16'h0001);
    pin("rst_t2_operand", 16'(b0.operand_lo), 16'h0000);
    tick();

    for (int c = 0; c < 3000; c++) begin
      if (m_phase[0] == 0 && $urandom_range(0, 99) < 90)
        d = legal[$urandom_range(0, 10)];
      else
        d = 8'($urandom_range(0, 255));
      drive(d, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 2));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
